// File: rtl/npu_mem_pkg.sv
// Shared types and constants for the image RAM port A arbiter.
// Address map, requester id and request bundle types.
package npu_mem_pkg;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int IMG_BASE = 0;
  localparam int OUT_BASE = 160000;
  localparam int IMG_W    = 400;
  localparam int DEPTH    = 320000;
  localparam int MAX_REQ  = 4;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic req_id_t id_next(
    input req_id_t id,
    input int      n
  );
    if (int'(id) >= n - 1)
      return '0;
    return id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// Combinational round-robin picker with lock-owner priority.
// A live lock owner wins; otherwise search starts at the pointer.
module rr_arbiter
  import npu_mem_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  req_id_t            ptr,
  input  logic               owner_vld,
  input  req_id_t            owner,
  output logic [NUM_REQ-1:0] gnt,
  output req_id_t            id
);

  logic found;
  int   j;

  // Owner keeps the port while it still requests with lock held.
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    j     = 0;
    if (owner_vld && req[owner] && lock[owner]) begin
      gnt[owner] = 1'b1;
      id         = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(ptr) + k;
        if (j >= NUM_REQ)
          j = j - NUM_REQ;
        if (!found && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          id     = req_id_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Port A arbiter for the dual-port image RAM.
// Registers the winning access and routes read data back by tag.
module ram_port_arbiter
  import npu_mem_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 320000,
  parameter int RAM_LATENCY = 1,
  parameter int MAX_BURST   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err_oob,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_wren,
  input  logic [DATA_W-1:0]         ram_q
);

  localparam int TD    = 1 + RAM_LATENCY;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  req_id_t            ptr;
  req_id_t            owner;
  logic               owner_vld;
  logic [CNT_W-1:0]   burst;
  logic [CNT_W-1:0]   bnext;

  logic [NUM_REQ-1:0] gnt_c;
  req_id_t            gid;
  logic               acc;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               in_rng;
  logic               owner_live;

  logic               tag_v  [TD];
  req_id_t            tag_id [TD];
  logic [NUM_REQ-1:0] rv_next;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req      (req),
    .lock     (lock),
    .ptr      (ptr),
    .owner_vld(owner_vld),
    .owner    (owner),
    .gnt      (gnt_c),
    .id       (gid)
  );

  assign gnt        = gnt_c;
  assign acc        = |(req & gnt_c);
  assign sel_we     = we[gid];
  assign sel_addr   = addr[int'(gid)*ADDR_W +: ADDR_W];
  assign sel_wdata  = wdata[int'(gid)*DATA_W +: DATA_W];
  assign in_rng     = (32'(sel_addr) < 32'(DEPTH));
  assign owner_live = req[owner] & lock[owner];
  assign bnext      = (owner_vld && owner == gid) ?
                      burst + 1'b1 : CNT_W'(1);
  assign rdata      = ram_q;

  // Pointer, lock owner and burst length; forced release at MAX_BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      burst     <= '0;
    end else if (acc) begin
      ptr <= id_next(gid, NUM_REQ);
      if (lock[gid] && bnext < CNT_W'(MAX_BURST)) begin
        owner_vld <= 1'b1;
        owner     <= gid;
        burst     <= bnext;
      end else begin
        owner_vld <= 1'b0;
        burst     <= '0;
      end
    end else if (owner_vld && !owner_live) begin
      owner_vld <= 1'b0;
      burst     <= '0;
    end
  end

  // RAM port registers; out-of-range writes never reach the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
      err_oob   <= 1'b0;
    end else begin
      ram_wren <= acc & sel_we & in_rng;
      err_oob  <= acc & ~in_rng;
      if (acc) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
    end
  end

  // Read tag pipe tracking which requester owns each RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TD; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= acc & ~sel_we & in_rng;
      tag_id[0] <= gid;
      for (int k = 1; k < TD; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Decode the oldest tag into a one-hot valid.
  always_comb begin
    rv_next = '0;
    if (tag_v[TD-1])
      rv_next[tag_id[TD-1]] = 1'b1;
  end

  // rvalid lines up with ram_q for the tagged read.
  always_ff @(posedge clk) begin
    if (rst)
      rvalid <= '0;
    else
      rvalid <= rv_next;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small RAM model.
// Each comparison is an immediate assertion.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, lock, we;
  logic [18:0] a [3];
  logic [7:0]  wd [3];
  logic [56:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata;
  logic        err_oob;
  logic [18:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_wren;
  logic [7:0]  ram_q;

  logic [7:0]  mem [1024];
  logic [7:0]  q1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign addr  = {a[2], a[1], a[0]};
  assign wdata = {wd[2], wd[1], wd[0]};

  ram_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err_oob  (err_oob),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  // RAM model: address sampled one edge after the arbiter registers it,
  // q valid one cycle later, read-old-data on a same-address write.
  always @(posedge clk) begin
    if (ram_wren)
      mem[ram_addr[9:0]] <= ram_wdata;
    q1    <= mem[ram_addr[9:0]];
    ram_q <= q1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = (i < 10) ? 8'(10 + i) : 8'h00;
    q1    = '0;
    ram_q = '0;
    rst   = 1'b1;
    req   = '0;
    lock  = '0;
    we    = '0;
    for (int i = 0; i < 3; i++) begin
      a[i]  = '0;
      wd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err", 32'(err_oob), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_wren", 32'(ram_wren), 32'h0);
    rst = 1'b0;

    // rotation with all three requesting, no lock
    req = 3'b111; we = 3'b111;
    a[0] = 19'd100; a[1] = 19'd101; a[2] = 19'd102;
    #1 chk("rr0", 32'(gnt), 32'b001);
    step(); chk("rr1", 32'(gnt), 32'b010);
    chk("rr_addr0", 32'(ram_addr), 32'd100);
    step(); chk("rr2", 32'(gnt), 32'b100);
    step(); chk("rr3", 32'(gnt), 32'b001);
    step();
    req = '0; we = '0;

    // back-to-back reads by requester 1
    for (int i = 0; i < 13; i++) begin
      if (i < 10) begin
        req  = 3'b010;
        a[1] = 19'(i);
        #1 chk("rd_gnt", 32'(gnt), 32'b010);
      end else begin
        req = '0;
      end
      step();
      if (i >= 2 && i < 12) begin
        chk("rd_valid", 32'(rvalid), 32'b010);
        chk("rd_data", 32'(rdata), 32'(10 + i - 2));
      end else begin
        chk("rd_idle", 32'(rvalid), 32'h0);
      end
    end

    // single write from requester 0
    req = 3'b001; we = 3'b001; a[0] = 19'd5; wd[0] = 8'hAB;
    #1 chk("wr_gnt", 32'(gnt), 32'b001);
    step();
    req = '0; we = '0;
    chk("wr_wren", 32'(ram_wren), 32'h1);
    chk("wr_addr", 32'(ram_addr), 32'd5);
    chk("wr_wdata", 32'(ram_wdata), 32'hAB);
    step();
    chk("wr_wren_off", 32'(ram_wren), 32'h0);
    chk("wr_addr_hold", 32'(ram_addr), 32'd5);

    // locked burst from requester 2
    we = 3'b111;
    a[0] = 19'd200; a[1] = 19'd201; a[2] = 19'd202;
    req = 3'b100; lock = 3'b100;
    #1 chk("lk_first", 32'(gnt), 32'b100);
    step();
    req = 3'b111;
    for (int i = 0; i < 15; i++) begin
      #1 chk("lk_hold", 32'(gnt), 32'b100);
      step();
    end
    chk("lk_rel0", 32'(gnt), 32'b001);
    step(); chk("lk_rel1", 32'(gnt), 32'b010);
    step(); chk("lk_back", 32'(gnt), 32'b100);
    step();
    req = '0; lock = '0; we = '0;
    step();

    // out-of-range write then read
    req = 3'b001; we = 3'b001; a[0] = 19'd320000;
    #1 chk("oob_w_gnt", 32'(gnt), 32'b001);
    step();
    req = '0;
    chk("oob_w_wren", 32'(ram_wren), 32'h0);
    chk("oob_w_err", 32'(err_oob), 32'h1);
    step();
    chk("oob_w_err_end", 32'(err_oob), 32'h0);
    req = 3'b001; we = 3'b000; a[0] = 19'd320005;
    #1 chk("oob_r_gnt", 32'(gnt), 32'b001);
    step();
    req = '0;
    chk("oob_r_err", 32'(err_oob), 32'h1);
    step();
    chk("oob_r_err_end", 32'(err_oob), 32'h0);
    chk("oob_r_rv0", 32'(rvalid), 32'h0);
    step();
    chk("oob_r_rv1", 32'(rvalid), 32'h0);

    // reset with two reads in flight
    req = 3'b010; we = '0; a[1] = 19'd3;
    step();
    a[1] = 19'd4;
    step();
    req = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_rv", 32'(rvalid), 32'h0);
    chk("mrst_addr", 32'(ram_addr), 32'h0);
    chk("mrst_wren", 32'(ram_wren), 32'h0);
    chk("mrst_err", 32'(err_oob), 32'h0);
    chk("mrst_gnt", 32'(gnt), 32'h0);
    step();
    chk("mrst_rv_late", 32'(rvalid), 32'h0);
    req = 3'b111; we = 3'b111;
    #1 chk("mrst_ptr", 32'(gnt), 32'b001);
    req = '0; we = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
